// File: rtl/kcpsm3_irq_pkg.sv
// Shared types and helpers for the KCPSM3 interrupt collector.
package kcpsm3_irq_pkg;

  localparam int NUM_SRC = 5;
  localparam int SRC_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_e;

  // Lowest set index wins; zero when nothing is set.
  function automatic logic [SRC_W-1:0] prio_enc5(
    input logic [NUM_SRC-1:0] a
  );
    logic [SRC_W-1:0] enc;
    enc = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (a[i]) enc = SRC_W'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/kcpsm3_irq_collector_sync.sv
// One-bit synchronizer plus falling-edge detector for an active-low request.
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_n,
  output logic sync_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_n};
    prev_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  // Edges only count once both compared samples came from the pin,
  // so a line held low across reset is never mistaken for a new edge.
  assign sync_o = sync_q[STAGES-1];
  assign fall_o = vld_q[STAGES] & prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/kcpsm3_irq_collector.sv
// Five-source interrupt collector for KCPSM3: sync, latch, mask, ack, holdoff.
// Define KCPSM3_IRQ_LEVEL_MODE_EN for level-sensitive pending bits.
module kcpsm3_irq_collector
  import kcpsm3_irq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_n,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               clear_we,
  input  logic [NUM_SRC-1:0] clear_data,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [SRC_W-1:0]   src_id,
  output logic [NUM_SRC-1:0] pending
);

  logic [NUM_SRC-1:0] syn, fall;
  logic [NUM_SRC-1:0] active, ack_clr;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [SRC_W-1:0]   src_q, src_d, enc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic               int_q, int_d;
  logic               any;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_n    (req_n[g]),
      .sync_o (syn[g]),
      .fall_o (fall[g])
    );
  end

  always_comb begin
    active  = pend_q & mask;
    any     = |active;
    enc     = prio_enc5(active);
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (any) state_d = ASSERT;
      end
      ASSERT: begin
        if (!any) begin
          state_d = IDLE;
        end else if (interrupt_ack) begin
          src_d   = enc;
          ack_clr = {{(NUM_SRC-1){1'b0}}, 1'b1} << enc;
          cnt_d   = CNT_W'(HOLDOFF_CYCLES);
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_d = (state_d == ASSERT);
  end

`ifdef KCPSM3_IRQ_LEVEL_MODE_EN
  logic unused_clr;
  assign unused_clr = ^{clear_we, clear_data, ack_clr, fall};

  always_comb begin
    pend_d = ~syn;
  end
`else
  logic unused_syn;
  assign unused_syn = ^syn;

  // Set wins over both software clear and ack clear.
  always_comb begin
    pend_d = pend_q & ~(ack_clr | (clear_we ? clear_data : '0));
    pend_d = pend_d | fall;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      pend_q  <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
    end
  end

  assign interrupt = int_q;
  assign src_id    = src_q;
  assign pending   = pend_q;

endmodule
